// File: rtl/emu_scan_pkg.sv
// Shared types and constants for the emulation scan-chain controller.
package emu_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FREEZE = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_DONE   = 3'd3,
    ST_STEP   = 3'd4
  } scan_state_t;

  localparam logic SCAN_DUMP = 1'b0;
  localparam logic SCAN_LOAD = 1'b1;

endpackage

// File: rtl/emu_step_timer.sv
// Down-counter with load, enable and zero flag; paces single-step runs of the target.
module emu_step_timer #(
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [STEP_W-1:0] load_value,
  input  logic              en,
  output logic              zero
);

  logic [STEP_W-1:0] count;

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - STEP_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/emu_scan_ctrl.sv
// Scan-chain controller: freezes the target, dumps (recirculating) or loads the chain, resumes.
// Optional single-step support is compiled in with `define EMU_SCAN_STEP_EN.
module emu_scan_ctrl
  import emu_scan_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int CHAIN_WORDS = 6
`ifdef EMU_SCAN_STEP_EN
  ,
  parameter int STEP_W      = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_en,
  output logic                  tgt_ce,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_load,
  output logic                  scan_shift,
  input  logic [DATA_WIDTH-1:0] scan_out,
  output logic [DATA_WIDTH-1:0] scan_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  busy,
  output logic                  done
`ifdef EMU_SCAN_STEP_EN
  ,
  input  logic                  step_valid,
  input  logic [STEP_W-1:0]     step_cycles
`endif
);

  localparam int CNT_W = $clog2(CHAIN_WORDS + 1);

  scan_state_t      state;
  scan_state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             mode;
  logic             accept;
  logic             shifting;
  logic             last_shift;
  logic             tgt_ce_nxt;

  assign cmd_ready  = (state == ST_IDLE);
  assign accept     = cmd_valid & cmd_ready;
  assign shifting   = (state == ST_SHIFT);
  assign out_valid  = shifting & (mode == SCAN_DUMP);
  assign in_ready   = shifting & (mode == SCAN_LOAD);
  assign scan_shift = (out_valid & out_ready) | (in_valid & in_ready);
  // Dumps recirculate the head word so the chain is left intact.
  assign scan_in    = in_ready ? in_data : scan_out;
  assign out_data   = scan_out;
  assign last_shift = scan_shift & (cnt == CNT_W'(CHAIN_WORDS - 1));
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);

`ifdef EMU_SCAN_STEP_EN
  logic              step_start;
  logic              step_zero;
  logic [STEP_W-1:0] step_load_value;

  assign step_start      = cmd_ready & ~cmd_valid & step_valid & ~run_en & (step_cycles != '0);
  // Timer holds the cycles remaining after the current one, so STEP lasts step_cycles cycles.
  assign step_load_value = step_cycles - STEP_W'(1);

  emu_step_timer #(
    .STEP_W(STEP_W)
  ) u_step_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (step_start),
    .load_value(step_load_value),
    .en        (state == ST_STEP),
    .zero      (step_zero)
  );
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_FREEZE;
        end
`ifdef EMU_SCAN_STEP_EN
        else if (step_start) begin
          state_nxt = ST_STEP;
        end
`endif
      end
      ST_FREEZE: state_nxt = ST_SHIFT;
      ST_SHIFT:  if (last_shift) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
`ifdef EMU_SCAN_STEP_EN
      ST_STEP:   if (step_zero) state_nxt = ST_DONE;
`endif
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // The target only runs when it will be idle next cycle; stepping forces it on.
  assign tgt_ce_nxt = ((state_nxt == ST_IDLE) && !accept) ? run_en : (state_nxt == ST_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mode   <= SCAN_DUMP;
      tgt_ce <= 1'b0;
    end else begin
      state  <= state_nxt;
      tgt_ce <= tgt_ce_nxt;
      if (accept) begin
        mode <= cmd_load;
        cnt  <= '0;
      end else if (scan_shift) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/emu_scan_ctrl.md
# emu_scan_ctrl

Scan-chain controller for emulated register state. Sits between the emulator host interface and a target design's flip-flop groups converted into a word-wide scan chain. On command it freezes the target clock enable, then dumps the chain state to a stream non-destructively (recirculating) or loads it from a stream, and finally resumes the target.

## Interface

- `DATA_WIDTH`, 32: scan word width, equal to the chain width.
- `CHAIN_WORDS`, 6: words in the chain (184 state bits pad to 6×32); must be ≥1.
- `CNT_W`, `$clog2(CHAIN_WORDS+1)`: shift-counter width (localparam).
- `STEP_W`, 16: step-count width (only with `EMU_SCAN_STEP_EN`).

One clock; reset is synchronous and active-high.

- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `run_en`, in, 1: host requests free-running target.
- `tgt_ce`, out, 1: target clock enable, registered.
- `cmd_valid`, in, 1: scan command request.
- `cmd_ready`, out, 1: command accepted when both valid and ready are high.
- `cmd_load`, in, 1: 0 selects dump, 1 selects load; sampled at acceptance.
- `scan_shift`, out, 1: chain shift strobe. The chain advances one word at a `clk` edge where this is high.
- `scan_out`, in, DATA_WIDTH: head word from the chain.
- `scan_in`, out, DATA_WIDTH: word entering the chain tail.
- `out_valid`, out, 1: dump stream valid.
- `out_ready`, in, 1: dump stream ready.
- `out_data`, out, DATA_WIDTH: dump stream data.
- `in_valid`, in, 1: load stream valid.
- `in_ready`, out, 1: load stream ready.
- `in_data`, in, DATA_WIDTH: load stream data.
- `busy`, out, 1: state is not IDLE.
- `done`, out, 1: one-cycle pulse when a scan completes.
- `step_valid`, in, 1: step request (`EMU_SCAN_STEP_EN` only).
- `step_cycles`, in, STEP_W: number of cycles to step (`EMU_SCAN_STEP_EN` only).

## Operation

States are IDLE, FREEZE, SHIFT, DONE (plus STEP when the feature is compiled in).

- **IDLE**
  - `cmd_ready`=1.
  - On acceptance: latch `cmd_load`, clear the counter, go to FREEZE.
- **FREEZE**
  - Lasts one cycle, which guarantees the target saw `tgt_ce`=0 for a full edge before any shift.
  - Always goes to SHIFT.
- **SHIFT, dump mode**
  - `out_valid`=1, `out_data`=`scan_out`, `scan_in`=`scan_out` (recirculate).
  - `scan_shift` = `out_valid & out_ready`, combinational.
- **SHIFT, load mode**
  - `in_ready`=1, `scan_in`=`in_data`.
  - `scan_shift` = `in_valid & in_ready`.
- **SHIFT, counting**
  - Each shift increments the counter.
  - The shift that makes count == CHAIN_WORDS moves to DONE.
- **DONE**
  - `done`=1 for one cycle, then IDLE.
- **`tgt_ce`** (registered): next value = `run_en` when next state is IDLE and no command is being accepted; otherwise 0.
- **Idle stream outputs:** outside SHIFT, `scan_shift`, `out_valid` and `in_ready` are 0, and `scan_in`=`scan_out`.
- **Reset values:**
  - State IDLE, counter 0.
  - `tgt_ce`=0, `done`=0, `busy`=0, `scan_shift`=0, `out_valid`=0, `in_ready`=0.
  - Reset mid-scan abandons the operation immediately. A partially shifted chain is left as is; recovering it is the host's responsibility.
- **Simultaneous events:**
  - `cmd_valid` has priority over `step_valid` in IDLE.
  - `run_en` toggling during a scan has no effect until return to IDLE.

## Timing

- Command accepted at edge 0:
  - `tgt_ce`=0 from cycle 1.
  - FREEZE in cycle 1.
  - First word offered in cycle 2.
- Full-throughput scan:
  - Shifts in cycles 2..CHAIN_WORDS+1.
  - DONE in cycle CHAIN_WORDS+2.
  - `tgt_ce`=`run_en` from cycle CHAIN_WORDS+3.
- Back-pressure:
  - A stall (ready/valid low) holds the state and counter, with no shift.
  - `out_data` tracks `scan_out`, which is stable while unshifted.
- A new command can be accepted in the cycle after DONE.

## Configuration

- `EMU_SCAN_STEP_EN` defined:
  - Adds the `step_valid`/`step_cycles` ports and the STEP state.
  - In IDLE with `run_en`=0 and `step_cycles`≠0, `step_valid` loads the timer and enters STEP.
  - STEP drives `tgt_ce`=1 for exactly `step_cycles` cycles, then returns to IDLE with a `done` pulse.
  - `cmd_ready`=0 during STEP.
  - `step_cycles`=0 is ignored.
- `EMU_SCAN_STEP_EN` undefined: none of the above ports or logic exist.

## Structure

- Package `emu_scan_pkg` holds:
  - the state enum `scan_state_t`;
  - the mode constants `SCAN_DUMP`=0 and `SCAN_LOAD`=1.
- Sub-module `emu_step_timer` (down-counter with load, enable and zero flag) is instantiated only under `EMU_SCAN_STEP_EN`.

## Test plan

- **Dump at full throughput.** Chain preset to words 0..5 = 0x10..0x15, `out_ready`=1, `run_en`=1. Expect:
  - `tgt_ce` low for exactly cycles 1..CHAIN_WORDS+2;
  - stream 0x10..0x15;
  - chain contents unchanged afterwards;
  - one `done` pulse.
- **Load, then verify.** Load stream 0xA0..0xA5, then dump. Expect the dump to return 0xA0..0xA5 and the target registers to hold the loaded values.
- **Back-pressure.** Toggle `out_ready` (load: `in_valid`) every other cycle. Expect exactly 6 shifts, no duplicated or dropped words, and DONE at cycle 2+11.
- **Reset mid-scan.** Assert `rst` after 3 shifts. Expect the next cycle to show IDLE, `tgt_ce`=0, `busy`=0, no `done`; a subsequent command completes normally.
- **Command/run interaction.** `cmd_valid` held high with `run_en`=1. Expect back-to-back scans, with `tgt_ce` high for one cycle between them.
- **Stepping (`EMU_SCAN_STEP_EN`).** `run_en`=0, `step_cycles`=5. Expect `tgt_ce`=1 for exactly 5 cycles, a q-register count advance of 5, and a `done` pulse; `step_cycles`=0 gives no response.
